// File: rtl/ppm_encoder.sv
// 4-channel PPM frame generator. Command bytes are latched at frame start and
// serialised as separator-low / slot-high pulses on a microsecond timebase.
module ppm_encoder #(
  parameter int unsigned CLK_PER_US = 27,
  parameter int unsigned FRAME_US   = 22500,
  parameter int unsigned SEP_US     = 300,
  parameter int unsigned BASE_US    = 1000,
  parameter int unsigned STEP_US    = 4,
  parameter int unsigned MAX_VAL    = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] roll,
  input  logic [7:0] pitch,
  input  logic [7:0] throttle,
  input  logic [7:0] yaw,
  output logic       ppm_out,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  typedef enum logic [1:0] {StIdle, StSep, StChan, StSync} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [14:0]   us_cnt_q, us_cnt_d;
  logic [14:0]   frame_cnt_q, frame_cnt_d;
  logic [2:0]    ch_idx_q, ch_idx_d;
  logic [7:0]    val_q [4];
  logic [7:0]    val_d [4];
  logic          ppm_out_q, ppm_out_d;
  logic          frame_start_q, frame_start_d;
  logic          busy_q, busy_d;

  logic          us_tick;
  logic [7:0]    cur_val;
  logic [14:0]   clamp_val;
  logic [14:0]   slot_us;
  logic [14:0]   chan_last;
  logic          sep_last;
  logic          frame_last;
  logic          start;

  always_comb begin
    us_tick    = (state_q != StIdle) && (presc_q == PW'(CLK_PER_US - 1));
    cur_val    = val_q[ch_idx_q[1:0]];
    clamp_val  = (32'(cur_val) > MAX_VAL) ? 15'(MAX_VAL) : 15'(cur_val);
    slot_us    = 15'(BASE_US) + 15'(STEP_US) * clamp_val;
    // The separator is part of the slot, so the high phase is the remainder.
    chan_last  = slot_us - 15'(SEP_US) - 15'd1;
    sep_last   = (us_cnt_q == 15'(SEP_US - 1));
    frame_last = (frame_cnt_q == 15'(FRAME_US - 1));
    start      = enable &&
                 ((state_q == StIdle) || ((state_q == StSync) && us_tick && frame_last));
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    us_cnt_d    = us_cnt_q;
    frame_cnt_d = frame_cnt_q;
    ch_idx_d    = ch_idx_q;
    val_d       = val_q;

    if (state_q != StIdle) begin
      presc_d = us_tick ? '0 : presc_q + PW'(1);
    end
    if (us_tick) begin
      us_cnt_d    = us_cnt_q + 15'd1;
      frame_cnt_d = frame_cnt_q + 15'd1;
    end

    unique case (state_q)
      StSep: begin
        if (us_tick && sep_last) begin
          us_cnt_d = '0;
          state_d  = (ch_idx_q < 3'd4) ? StChan : StSync;
        end
      end
      StChan: begin
        if (us_tick && (us_cnt_q == chan_last)) begin
          us_cnt_d = '0;
          ch_idx_d = ch_idx_q + 3'd1;
          state_d  = StSep;
        end
      end
      StSync: begin
        if (us_tick && frame_last) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    // Frame start overrides everything, including the end of a previous frame.
    if (start) begin
      state_d     = StSep;
      val_d[0]    = roll;
      val_d[1]    = pitch;
      val_d[2]    = throttle;
      val_d[3]    = yaw;
      ch_idx_d    = '0;
      us_cnt_d    = '0;
      frame_cnt_d = '0;
      presc_d     = '0;
    end

    frame_start_d = start;
    ppm_out_d     = (state_d != StSep);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      us_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      ch_idx_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        val_q[i] <= 8'd116;
      end
      ppm_out_q     <= 1'b1;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      ch_idx_q      <= ch_idx_d;
      val_q         <= val_d;
      ppm_out_q     <= ppm_out_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign ppm_out     = ppm_out_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Directed bench for ppm_encoder: a default-parameter instance checks real
// separator/slot timing, a scaled instance exercises whole frames quickly.
module tb_ppm_encoder;

  logic       clock = 1'b0;
  logic       reset, enable, def_en;
  logic [7:0] roll, pitch, throttle, yaw;
  logic       ppm_out, frame_start, busy;
  logic       d_ppm, d_fs, d_busy;

  always #5 clock = ~clock;

  // Scaled: 2 clk/us, slot = 100 + min(v,250) us, sep 30 us, frame 1500 us.
  ppm_encoder #(
    .CLK_PER_US(2),
    .FRAME_US  (1500),
    .SEP_US    (30),
    .BASE_US   (100),
    .STEP_US   (1),
    .MAX_VAL   (250)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .roll       (roll),
    .pitch      (pitch),
    .throttle   (throttle),
    .yaw        (yaw),
    .ppm_out    (ppm_out),
    .frame_start(frame_start),
    .busy       (busy)
  );

  ppm_encoder u_def (
    .clock      (clock),
    .reset      (reset),
    .enable     (def_en),
    .roll       (roll),
    .pitch      (pitch),
    .throttle   (throttle),
    .yaw        (yaw),
    .ppm_out    (d_ppm),
    .frame_start(d_fs),
    .busy       (d_busy)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_fs = 0;
  int   busy_fall = 0;
  int   t0;
  int   fall_q[$], rise_q[$], fs_q[$], d_fall_q[$], d_rise_q[$];
  logic prev_ppm = 1'b1, prev_busy = 1'b0, d_prev = 1'b1;

  always @(negedge clock) begin
    cyc       <= cyc + 1;
    prev_ppm  <= ppm_out;
    prev_busy <= busy;
    d_prev    <= d_ppm;
    if (prev_ppm && !ppm_out) fall_q.push_back(cyc + 1);
    if (!prev_ppm && ppm_out) rise_q.push_back(cyc + 1);
    if (frame_start) fs_q.push_back(cyc + 1);
    if (prev_busy && !busy) busy_fall <= cyc + 1;
    if (d_prev && !d_ppm) d_fall_q.push_back(cyc + 1);
    if (!d_prev && d_ppm) d_rise_q.push_back(cyc + 1);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input bit gap_chk);
    fall_q.delete();
    rise_q.delete();
    fs_q.delete();
    for (int i = 0; i < 4000 && fs_q.size() == 0; i++) step();
    chk("fs_seen", fs_q.size(), 1);
    if (fs_q.size() > 0) begin
      if (gap_chk) chk("frame_gap", fs_q[0] - last_fs, 3000);
      last_fs = fs_q[0];
    end
  endtask

  // Spans are falling-edge to falling-edge, in clocks.
  task automatic finish_frame(input int s0, input int s1, input int s2, input int s3);
    int sp[4];
    sp = '{s0, s1, s2, s3};
    for (int i = 0; i < 3000 && cyc < last_fs + 2990; i++) step();
    chk("fs_once", fs_q.size(), 1);
    chk("fall_cnt", fall_q.size(), 5);
    chk("rise_cnt", rise_q.size(), 5);
    if (fall_q.size() == 5 && rise_q.size() == 5) begin
      chk("fall_at_fs", fall_q[0], last_fs);
      for (int i = 0; i < 5; i++) chk($sformatf("sep%0d", i), rise_q[i] - fall_q[i], 60);
      for (int i = 0; i < 4; i++) chk($sformatf("span%0d", i), fall_q[i+1] - fall_q[i], sp[i]);
    end
    chk("busy_in_sync", int'(busy), 1);
    chk("ppm_in_sync", int'(ppm_out), 1);
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    def_en   = 1'b0;
    roll     = 8'd116;
    pitch    = 8'd116;
    throttle = 8'd116;
    yaw      = 8'd116;
    repeat (3) step();
    chk("rst_ppm", int'(ppm_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fs", int'(frame_start), 0);
    reset = 1'b1;
    step();
    step();

    // Default parameters: 8100-clock separator, 1464 us slot -> 31428-clock high.
    d_fall_q.delete();
    d_rise_q.delete();
    t0 = cyc;
    def_en = 1'b1;
    for (int i = 0; i < 45000 && d_fall_q.size() < 2; i++) step();
    chk("def_fall_cnt", d_fall_q.size(), 2);
    if (d_fall_q.size() >= 2) begin
      chk("def_start", d_fall_q[0], t0 + 1);
      chk("def_sep", d_rise_q[0] - d_fall_q[0], 8100);
      chk("def_chan", d_fall_q[1] - d_rise_q[0], 31428);
    end
    def_en = 1'b0;

    // Neutral frame.
    t0 = cyc;
    enable = 1'b1;
    start_frame(1'b0);
    chk("fs_latency", last_fs, t0 + 1);
    finish_frame(432, 432, 432, 432);

    roll     = 8'd0;
    pitch    = 8'd58;
    throttle = 8'd174;
    yaw      = 8'd250;
    start_frame(1'b1);
    finish_frame(200, 316, 548, 700);

    // Pitch changes during channel 1; current frame must keep the old slot.
    start_frame(1'b1);
    repeat (300) step();
    pitch = 8'd174;
    finish_frame(200, 316, 548, 700);

    start_frame(1'b1);
    finish_frame(200, 548, 548, 700);

    yaw = 8'd255;
    start_frame(1'b1);
    finish_frame(200, 548, 548, 700);

    // Enable dropped during channel 2.
    start_frame(1'b1);
    repeat (900) step();
    enable = 1'b0;
    roll   = 8'd250;
    finish_frame(200, 548, 548, 700);
    repeat (100) step();
    chk("stop_busy", int'(busy), 0);
    chk("stop_ppm", int'(ppm_out), 1);
    chk("stop_busy_fall", busy_fall - last_fs, 3000);
    chk("stop_no_fs", fs_q.size(), 1);

    // Reset while the separator is low.
    roll   = 8'd0;
    enable = 1'b1;
    start_frame(1'b0);
    repeat (10) step();
    chk("sep_low", int'(ppm_out), 0);
    reset = 1'b0;
    #1;
    chk("async_ppm", int'(ppm_out), 1);
    chk("async_busy", int'(busy), 0);
    step();
    step();
    fall_q.delete();
    rise_q.delete();
    fs_q.delete();
    t0 = cyc;
    reset = 1'b1;
    step();
    step();
    chk("restart_fs_cnt", fs_q.size(), 1);
    if (fs_q.size() > 0) begin
      chk("restart_fs_time", fs_q[0], t0 + 1);
      last_fs = fs_q[0];
      finish_frame(200, 548, 548, 700);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppm_encoder.md
Name: ppm_encoder

Overview:
- Downstream of the gesture-to-command stages (pitch, roll, throttle, yaw). Takes their 8-bit command bytes and serialises them into a standard 4-channel PPM frame for the drone's RC transmitter trainer port.
- Command values are latched once per frame, so a command that changes mid-frame never produces a torn frame.
- A free-running microsecond timebase, derived from the system clock, sets all pulse timing.

Parameters:
- CLK_PER_US, 27, system clocks per microsecond (prescaler terminal count + 1).
- FRAME_US, 22500, total frame length in µs.
- SEP_US, 300, low separator pulse width in µs.
- BASE_US, 1000, channel slot width in µs for command value 0.
- STEP_US, 4, additional µs per command LSB.
- MAX_VAL, 250, command saturation limit (250 -> 2000 µs slot).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- enable  in  1  level: 1 = generate frames back-to-back, 0 = stop at the end of the current frame.
- roll  in  8  channel 0 command (116 = neutral).
- pitch  in  8  channel 1 command.
- throttle  in  8  channel 2 command.
- yaw  in  8  channel 3 command.
- ppm_out  out  1  PPM waveform; idles high, separators are low.
- frame_start  out  1  one-cycle pulse when a frame begins and inputs are latched.
- busy  out  1  1 while a frame is in progress.

Behaviour:
- Reset (async assert, sync release): ppm_out=1, frame_start=0, busy=0, state=IDLE, all counters=0, latched values=116.
- Timebase:
  - Prescaler counts 0..CLK_PER_US-1 only while busy.
  - us_tick is asserted in the cycle where the prescaler = CLK_PER_US-1.
  - us_cnt (15 bits) and frame_cnt (15 bits) advance on us_tick.
- Slot width: slot_us = BASE_US + STEP_US*min(val, MAX_VAL), computed at 15-bit width with no overflow. Example: val 116 -> 1464 µs.
- States:
  - IDLE: ppm_out=1, busy=0. If enable=1 at a clock edge, the next state is SEP. On that same edge:
    - latch all four inputs;
    - ch_idx=0;
    - clear us_cnt, frame_cnt and the prescaler;
    - frame_start=1 for exactly that cycle.
  - SEP: ppm_out=0.
    - On the us_tick where us_cnt = SEP_US-1: clear us_cnt.
    - If ch_idx<4, go to CHAN; otherwise go to SYNC.
  - CHAN: ppm_out=1.
    - On the us_tick where us_cnt = slot_us(ch_idx)-SEP_US-1: clear us_cnt, increment ch_idx, go to SEP.
    - Each channel therefore spans exactly slot_us from the falling edge of its separator.
  - SYNC: ppm_out=1.
    - On the us_tick where frame_cnt = FRAME_US-1, the frame ends.
    - If enable=1, behave exactly as the IDLE start edge: go to SEP, latch, frame_start=1. Frames are back-to-back with no idle cycle.
    - Otherwise go to IDLE.
- Frame length is fixed at FRAME_US*CLK_PER_US clocks, regardless of channel values. The minimum sync gap is 22500-8000-300 = 14200 µs, so it is always positive.
- busy=1 in SEP, CHAN and SYNC.
- enable deasserted mid-frame: the frame completes unchanged and no truncation occurs.
- Input changes mid-frame are ignored until the next frame_start.
- Reset mid-frame: ppm_out goes high immediately (asynchronously), and the frame is abandoned.
- Values above MAX_VAL are clamped to MAX_VAL. Example: 255 -> 2000 µs.

Test Plan:
- Reset then enable=1, all channels 116:
  - frame_start pulses once;
  - ppm_out low for 8100 clocks, then high for 31428 clocks (1164 µs), repeated for 4 channels;
  - a fifth low of 8100 clocks;
  - the next frame_start arrives exactly 607500 clocks after the first.
- roll=0, pitch=58, throttle=174, yaw=250: channel spans are 1000/1232/1696/2000 µs, i.e. 27000/33264/45792/54000 clocks falling-edge to falling-edge.
- pitch changes 58->174 midway through channel 1: the current frame still shows a 1232 µs slot, and the next frame shows 1696 µs.
- yaw=255: slot is 2000 µs, identical to yaw=250.
- enable dropped during channel 2: the frame completes in full, busy falls at frame end, ppm_out stays high, and no further frame_start occurs.
- reset asserted while ppm_out is low in SEP: ppm_out=1 and busy=0 without waiting for a clock edge. On release with enable=1, a fresh frame starts on the first clock edge.
